// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo pulse generator.
package servo_pkg;

  localparam int unsigned DEF_NCH       = 2;
  localparam int unsigned DEF_PW        = 8;
  localparam int unsigned DEF_CW        = 18;

  // 12 MHz board timing: 20 ms frame, 0.5 ms base, ~7.8 us per position step
  localparam int unsigned DEF_FRAME_CYC = 240000;
  localparam int unsigned DEF_BASE_CYC  = 6000;
  localparam int unsigned DEF_STEP_CYC  = 94;

  // Shortened timing so a frame fits comfortably in simulation
  localparam int unsigned SIM_FRAME     = 400;
  localparam int unsigned SIM_BASE      = 20;
  localparam int unsigned SIM_STEP      = 1;

  // Pulse length in cycles for a position word; callers truncate to the counter width
  function automatic int unsigned pulse_cyc(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned p);
    return base + p * step;
  endfunction

  // Longest pulse any position can request, used for the configuration check
  function automatic longint unsigned max_pulse_cyc(input int unsigned base,
                                                    input int unsigned step,
                                                    input int unsigned pw);
    return 64'(base) + ((64'(1) << pw) - 64'(1)) * 64'(step);
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: shadow width register loaded at the frame boundary and
// a registered compare against the shared frame counter.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int unsigned PW       = DEF_PW,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned BASE_CYC = DEF_BASE_CYC,
  parameter int unsigned STEP_CYC = DEF_STEP_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          latch,
  input  logic          en_sh,
  input  logic [PW-1:0] pos_i,
  input  logic [CW-1:0] cnt,
  output logic          servo
);

  logic [CW-1:0] width_d, width_q;
  logic          servo_d, servo_q;

  // Width only changes at the latch strobe so a pulse in flight is never reshaped
  always_comb begin
    width_d = width_q;
    servo_d = en_sh && (cnt < width_q);
    if (latch) begin
      width_d = CW'(pulse_cyc(BASE_CYC, STEP_CYC, 32'(pos_i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q <= '0;
      servo_q <= 1'b0;
    end else begin
      width_q <= width_d;
      servo_q <= servo_d;
    end
  end

  assign servo = servo_q;

endmodule

// File: rtl/servo_frame_pwm.sv
// Multi-channel hobby-servo pulse generator sharing one frame counter; positions
// and enable are sampled only on the last cycle of each frame.
module servo_frame_pwm
  import servo_pkg::*;
#(
  parameter int unsigned NCH       = DEF_NCH,
  parameter int unsigned PW        = DEF_PW,
  parameter int unsigned FRAME_CYC = DEF_FRAME_CYC,
  parameter int unsigned BASE_CYC  = DEF_BASE_CYC,
  parameter int unsigned STEP_CYC  = DEF_STEP_CYC,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NCH*PW-1:0] pos,
  output logic [NCH-1:0]    servo,
  output logic              frame_tick
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYC - 1);

  // Reject configurations where the counter cannot span the frame or a pulse could fill it
  if ((64'(1) << CW) < 64'(FRAME_CYC)) begin : g_bad_cw
    $error("servo_frame_pwm: CW too narrow for FRAME_CYC");
  end
  if (max_pulse_cyc(BASE_CYC, STEP_CYC, PW) >= 64'(FRAME_CYC)) begin : g_bad_width
    $error("servo_frame_pwm: maximum pulse does not fit inside the frame");
  end

  logic [CW-1:0] cnt_d, cnt_q;
  logic          en_sh_d, en_sh_q;
  logic          frame_tick_d, frame_tick_q;
  logic          latch_c;

  always_comb begin
    latch_c      = (cnt_q == LAST_CNT);
    cnt_d        = latch_c ? '0 : cnt_q + CW'(1);
    en_sh_d      = latch_c ? ena : en_sh_q;
    // Registered so the strobe is high exactly while cnt_q is 0
    frame_tick_d = latch_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      en_sh_q      <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      en_sh_q      <= en_sh_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick = frame_tick_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    servo_pwm_chan #(
      .PW       (PW),
      .CW       (CW),
      .BASE_CYC (BASE_CYC),
      .STEP_CYC (STEP_CYC)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .latch (latch_c),
      .en_sh (en_sh_q),
      .pos_i (pos[i*PW +: PW]),
      .cnt   (cnt_q),
      .servo (servo[i])
    );
  end

endmodule

// File: tb/tb_servo_frame_pwm.sv
// Directed bench for servo_frame_pwm with a per-frame expected-width scoreboard.
module tb_servo_frame_pwm;
  import servo_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = 8;
  localparam int unsigned CW  = 18;
  localparam int          FRM = int'(SIM_FRAME);

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [NCH*PW-1:0] pos;
  logic [NCH-1:0]    servo;
  logic              frame_tick;

  always #5 clk = ~clk;

  servo_frame_pwm #(
    .NCH       (NCH),
    .PW        (PW),
    .FRAME_CYC (SIM_FRAME),
    .BASE_CYC  (SIM_BASE),
    .STEP_CYC  (SIM_STEP),
    .CW        (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .pos        (pos),
    .servo      (servo),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int w0;
    int w1;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_width(input int p, input bit en);
    return en ? int'(SIM_BASE) + p * int'(SIM_STEP) : 0;
  endfunction

  // Expected widths for the frame that will latch the values just driven
  task automatic push_exp(input int p0, input int p1, input bit en);
    exp_t e;
    e.w0 = model_width(p0, en);
    e.w1 = model_width(p1, en);
    sb.push_back(e);
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    check({tag, "_sb_level"}, 32'(sb.size() > 0 ? 1 : 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.w0 = 0;
      e.w1 = 0;
    end
  endtask

  // Wait for the first strobe after reset release; no output may pulse meanwhile
  task automatic wait_first_tick(input string tag);
    int cyc = 0;
    int hi  = 0;
    for (int k = 1; k <= FRM + 100; k++) begin
      @(posedge clk); #1;
      if (frame_tick === 1'b1) begin
        cyc = k;
        break;
      end
      if (servo !== '0) hi++;
    end
    check({tag, "_tick_cyc"}, 32'(cyc), 32'(FRM));
    check({tag, "_low"}, 32'(hi), 32'd0);
  endtask

  // Called at the sample point where frame_tick is high; checks one whole frame
  task automatic measure_frame(input string tag, input int chg_k, input int chg_p0,
                               input bit ena_latch);
    exp_t e;
    int hi0 = 0, hi1 = 0, bad0 = 0, bad1 = 0, tbad = 0;
    pop_exp(tag, e);
    for (int k = 1; k <= FRM; k++) begin
      @(posedge clk); #1;
      if (k < FRM) begin
        if (servo[0] === 1'b1) hi0++;
        if (servo[1] === 1'b1) hi1++;
        if (servo[0] !== ((k <= e.w0) ? 1'b1 : 1'b0)) bad0++;
        if (servo[1] !== ((k <= e.w1) ? 1'b1 : 1'b0)) bad1++;
        if (frame_tick !== 1'b0) tbad++;
      end else begin
        check({tag, "_period_tick"}, 32'(frame_tick), 32'd1);
        check({tag, "_wrap_low"}, 32'(servo), 32'd0);
      end
      if (k == chg_k) pos[PW-1:0] = PW'(chg_p0);
      if (k == FRM - 1) ena = ena_latch;
      if (k == FRM) ena = 1'b1;
    end
    check({tag, "_w0"}, 32'(hi0), 32'(e.w0));
    check({tag, "_w1"}, 32'(hi1), 32'(e.w1));
    check({tag, "_shape0"}, 32'(bad0), 32'd0);
    check({tag, "_shape1"}, 32'(bad1), 32'd0);
    check({tag, "_tick_extra"}, 32'(tbad), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   hi;

    rst = 1'b1;
    ena = 1'b1;
    pos = {8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_servo", 32'(servo), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
    end
    rst = 1'b0;

    // First frame stays dark; these positions latch at its end
    pos = {8'd255, 8'd0};
    push_exp(0, 255, 1'b1);
    wait_first_tick("boot");

    pos[7:0] = 8'd10;
    push_exp(10, 255, 1'b1);
    measure_frame("extremes", -1, 0, 1'b1);

    // Mid-frame change at cnt 15 must not affect the pulse in flight
    push_exp(200, 255, 1'b1);
    measure_frame("midchg", 15, 200, 1'b1);

    pos[15:8] = 8'd50;
    push_exp(200, 50, 1'b0);
    measure_frame("ena_low_latch", -1, 0, 1'b0);

    push_exp(200, 50, 1'b1);
    measure_frame("gated", -1, 0, 1'b1);

    pos = {8'd37, 8'd100};
    push_exp(100, 37, 1'b1);
    measure_frame("resume", -1, 0, 1'b1);

    // Reset at cnt 50 during a 120-cycle pulse
    pop_exp("rst_mid", e);
    hi = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (servo[0] === 1'b1) hi++;
    end
    check("rst_mid_pre_hi", 32'(hi), 32'(e.w0 < 50 ? e.w0 : 50));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_servo", 32'(servo), 32'd0);
    check("rst_mid_tick", 32'(frame_tick), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(100, 37, 1'b1);
    wait_first_tick("rst_mid_lowframe");

    pos[7:0] = 8'd37;
    push_exp(37, 37, 1'b1);
    measure_frame("after_rst", -1, 0, 1'b1);
    push_exp(37, 37, 1'b1);
    measure_frame("wrap1", -1, 0, 1'b1);
    push_exp(37, 37, 1'b1);
    measure_frame("wrap2", -1, 0, 1'b1);
    measure_frame("wrap3", -1, 0, 1'b1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(FRM * 10 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
